// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   UART_BYTE_W : width of one UART data byte
//   arb_state_t : states of the transmitter-sharing arbiter
//   LF, CR      : ASCII line-ending characters
//   ptr_w()     : width of an index into n requesters (never below 1 bit)
package uart_pkg;

   localparam int UART_BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      LOCKED = 2'd2
   } arb_state_t;

   localparam logic [UART_BYTE_W-1:0] LF = 8'h0A;
   localparam logic [UART_BYTE_W-1:0] CR = 8'h0D;

   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector, one bit per requester
//   rr_ptr : index that gets highest priority; priority falls with
//            increasing index and wraps around
//   winner : one-hot selected requester (zero when nothing requests)
//   found  : at least one request was present
module rr_pick
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 2,
   localparam int PTR_W = ptr_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic               found
);

   function automatic int wrap_idx(input int base, input int off, input int n);
      int s;
      s = base + off;
      return (s >= n) ? (s - n) : s;
   endfunction

   // Scan from the lowest priority to the highest so the last hit wins;
   // this avoids an early loop exit while keeping the priority order.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[wrap_idx(int'(rr_ptr), i, NUM_REQ)]) begin
            winner = '0;
            winner[wrap_idx(int'(rr_ptr), i, NUM_REQ)] = 1'b1;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources.
// A requester, once granted, owns the transmitter until it sends LOCK_CHAR
// or stays idle for LOCK_TIMEOUT cycles, so text lines never interleave.
//   clk, rst             : clock, synchronous active-low reset
//   req_data/valid/ready : per-requester byte streams (byte i in [8i+7:8i])
//   tx_data/valid/ready  : stream into the UART transmitter
//   grant                : one-hot current owner, zero when idle
//   busy                 : an owner is being set up or holds the line
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int                     NUM_REQ      = 2,
   parameter logic [UART_BYTE_W-1:0] LOCK_CHAR    = 8'h0A,
   parameter int                     LOCK_TIMEOUT = 1000
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [UART_BYTE_W-1:0]         tx_data,
   output logic                           tx_valid,
   input  logic                           tx_ready,
   output logic [NUM_REQ-1:0]             grant,
   output logic                           busy
);

   localparam int PTR_W = ptr_w(NUM_REQ);
   localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(NUM_REQ - 1);

   arb_state_t         state_reg, state_next;
   logic [NUM_REQ-1:0] grant_reg, grant_next;
   logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
   logic [CNT_W-1:0]   idle_cnt_reg, idle_cnt_next;

   logic [NUM_REQ-1:0]     winner;
   logic                   found;
   logic [PTR_W-1:0]       owner;
   logic [PTR_W-1:0]       ptr_after;
   logic [UART_BYTE_W-1:0] owner_data;
   logic                   owner_valid;
   logic [UART_BYTE_W-1:0] byte_arr [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign byte_arr[gi] = req_data[gi*UART_BYTE_W +: UART_BYTE_W];
      end
   endgenerate

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .req    (req_valid),
      .rr_ptr (rr_ptr_reg),
      .winner (winner),
      .found  (found)
   );

   // Grant is one-hot, so OR-ing the indices of set bits gives the owner.
   always_comb begin
      owner = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_reg[i]) begin
            owner = owner | PTR_W'(i);
         end
      end
   end

   assign owner_data  = byte_arr[owner];
   assign owner_valid = req_valid[owner];
   // The releasing owner drops to lowest priority on the next arbitration.
   assign ptr_after   = (owner == PTR_MAX) ? '0 : owner + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= IDLE;
         grant_reg    <= '0;
         rr_ptr_reg   <= '0;
         idle_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         grant_reg    <= grant_next;
         rr_ptr_reg   <= rr_ptr_next;
         idle_cnt_reg <= idle_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      grant_next    = grant_reg;
      rr_ptr_next   = rr_ptr_reg;
      idle_cnt_next = idle_cnt_reg;
      tx_data       = '0;
      tx_valid      = 1'b0;
      req_ready     = '0;

      case (state_reg)
         IDLE: begin
            if (found) begin
               grant_next    = winner;
               idle_cnt_next = '0;
               state_next    = GRANT;
            end
         end

         GRANT: begin
            idle_cnt_next = '0;
            state_next    = LOCKED;
         end

         LOCKED: begin
            tx_data   = owner_data;
            tx_valid  = owner_valid;
            req_ready = grant_reg & {NUM_REQ{tx_ready}};
            if (owner_valid) begin
               // A stalled but valid owner keeps the line indefinitely.
               idle_cnt_next = '0;
               if (tx_ready && (owner_data == LOCK_CHAR)) begin
                  state_next  = IDLE;
                  grant_next  = '0;
                  rr_ptr_next = ptr_after;
               end
            end else if (idle_cnt_reg == CNT_LAST) begin
               state_next    = IDLE;
               grant_next    = '0;
               rr_ptr_next   = ptr_after;
               idle_cnt_next = '0;
            end else begin
               idle_cnt_next = idle_cnt_reg + 1'b1;
            end
         end

         default: begin
            state_next = IDLE;
            grant_next = '0;
         end
      endcase
   end

   assign grant = grant_reg;
   assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with two requesters and a short
// lock timeout. Requesters are byte queues; every cycle's outputs are
// recorded and compared against hand-computed cycle positions.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] req_data;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [1:0]  grant;
   logic        busy;

   uart_tx_arbiter #(
      .NUM_REQ      (2),
      .LOCK_CHAR    (8'h0A),
      .LOCK_TIMEOUT (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_data  (req_data),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .grant     (grant),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   logic [7:0] q0 [$];
   logic [7:0] q1 [$];
   logic [1:0] gt [$];
   logic [1:0] rt [$];
   logic       vt [$];
   logic       bt [$];
   logic [7:0] xd [64];
   logic [1:0] xg [64];
   int         xc [64];
   int         xn = 0;
   int         cyc = 0;
   int         base = 0;
   int         pass_cnt = 0;
   int         chk_cnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic drive();
      req_valid[0]   = (q0.size() != 0);
      req_valid[1]   = (q1.size() != 0);
      req_data[7:0]  = (q0.size() != 0) ? q0[0] : 8'h00;
      req_data[15:8] = (q1.size() != 0) ? q1[0] : 8'h00;
   endtask

   // Sample on the falling edge, then update requester queues after the
   // rising edge that consumed any accepted byte.
   task automatic tick();
      logic [1:0] acc;
      @(negedge clk);
      acc = req_valid & req_ready;
      gt.push_back(grant);
      rt.push_back(req_ready);
      vt.push_back(tx_valid);
      bt.push_back(busy);
      if (tx_valid && tx_ready) begin
         if (xn < 64) begin
            xd[xn] = tx_data;
            xg[xn] = grant;
            xc[xn] = cyc;
         end
         $display("xfer cycle=%0d data=%02h grant=%b", cyc, tx_data, grant);
         xn++;
      end
      cyc++;
      @(posedge clk);
      #1;
      if (acc[0] && q0.size() != 0) void'(q0.pop_front());
      if (acc[1] && q1.size() != 0) void'(q1.pop_front());
      drive();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic start();
      drive();
      base = cyc;
      xn = 0;
   endtask

   initial begin
      logic [1:0] g;
      logic [1:0] r;
      int         bad;

      // Reset held with both requesters valid.
      rst = 1'b0;
      tx_ready = 1'b1;
      q0 = '{8'h55};
      q1 = '{8'h66};
      start();
      run(10);
      for (int k = 0; k < 10; k++) begin
         check("rst_grant", 32'(gt[base+k]), 0);
         check("rst_txvalid", 32'(vt[base+k]), 0);
         check("rst_ready", 32'(rt[base+k]), 0);
         check("rst_busy", 32'(bt[base+k]), 0);
      end
      rst = 1'b1;
      q0.delete();
      q1.delete();
      drive();
      run(2);

      // Single requester sends "hi\n".
      q0 = '{8'h68, 8'h69, 8'h0A};
      start();
      run(8);
      check("single_count", 32'(xn), 3);
      check("single_d0", 32'(xd[0]), 32'h68);
      check("single_d1", 32'(xd[1]), 32'h69);
      check("single_d2", 32'(xd[2]), 32'h0A);
      check("single_first_cyc", 32'(xc[0] - base), 2);
      check("single_last_cyc", 32'(xc[2] - base), 4);
      check("single_grant_c0", 32'(gt[base]), 0);
      check("single_grant_c1", 32'(gt[base+1]), 32'b01);
      check("single_busy_c1", 32'(bt[base+1]), 1);
      check("single_release", 32'(gt[base+5]), 0);

      // Fresh pointer, then both requesters contend.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      q0 = '{8'h61, 8'h62, 8'h0A};
      q1 = '{8'h63, 8'h64, 8'h0A};
      start();
      run(12);
      check("cont_count", 32'(xn), 6);
      check("cont_d0", 32'(xd[0]), 32'h61);
      check("cont_d1", 32'(xd[1]), 32'h62);
      check("cont_d2", 32'(xd[2]), 32'h0A);
      check("cont_d3", 32'(xd[3]), 32'h63);
      check("cont_d4", 32'(xd[4]), 32'h64);
      check("cont_d5", 32'(xd[5]), 32'h0A);
      check("cont_g0", 32'(xg[0]), 32'b01);
      check("cont_g3", 32'(xg[3]), 32'b10);
      check("cont_handover", 32'(xc[3] - xc[2]), 3);
      check("cont_grant1_cyc", 32'(gt[base+6]), 32'b10);
      for (int k = 1; k <= 5; k++) begin
         r = rt[base+k];
         check("cont_ready1_low", 32'(r[1]), 0);
      end

      // Single-byte lines, both continuously valid: strict alternation.
      q0 = '{8'h0A, 8'h0A, 8'h0A, 8'h0A};
      q1 = '{8'h0A, 8'h0A, 8'h0A, 8'h0A};
      start();
      run(30);
      check("rr_count", 32'(xn), 8);
      for (int i = 0; i < 8; i++) begin
         check("rr_grant", 32'(xg[i]), (i % 2 == 0) ? 32'b01 : 32'b10);
      end

      // Timeout: req1 sends one byte without a line end, req0 waits.
      q1 = '{8'h41};
      start();
      run(2);
      q0 = '{8'h42, 8'h0A};
      drive();
      run(24);
      check("to_first", 32'(xd[0]), 32'h41);
      check("to_first_cyc", 32'(xc[0] - base), 2);
      check("to_held", 32'(gt[base+18]), 32'b10);
      check("to_release", 32'(gt[base+19]), 0);
      check("to_regrant", 32'(gt[base+20]), 32'b01);
      check("to_next_data", 32'(xd[1]), 32'h42);
      check("to_next_cyc", 32'(xc[1] - base), 21);

      // Long stall with the owner valid: no forced release.
      tx_ready = 1'b0;
      q0 = '{8'h55, 8'h0A};
      start();
      run(5000);
      bad = 0;
      for (int k = 1; k < 5000; k++) begin
         g = gt[base+k];
         if (g != 2'b01) bad++;
      end
      check("stall_lost_grant", 32'(bad), 0);
      check("stall_xfers", 32'(xn), 0);
      check("stall_txvalid", 32'(tx_valid), 1);
      check("stall_txdata", 32'(tx_data), 32'h55);
      check("stall_busy", 32'(busy), 1);

      // One-cycle reset mid-stall; pointer must be back at requester 0.
      q1 = '{8'h0A};
      rst = 1'b0;
      drive();
      tick();
      rst = 1'b1;
      tx_ready = 1'b1;
      start();
      run(10);
      check("mrst_grant", 32'(gt[base]), 0);
      check("mrst_txvalid", 32'(vt[base]), 0);
      check("mrst_ready", 32'(rt[base]), 0);
      check("mrst_regrant", 32'(gt[base+1]), 32'b01);
      check("mrst_count", 32'(xn), 3);
      check("mrst_d0", 32'(xd[0]), 32'h55);
      check("mrst_g2", 32'(xg[2]), 32'b10);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
